spi_cmd_master: RTL and testbench
=================================

Name: spi_cmd_master

Overview:
- SPI master that drives the 4-wire command/response link served by the design's 32-bit SPI slave.
- Issues one full-duplex VALUE_WIDTH-bit frame per request: shifts a command word out on MOSI and captures the response word from MISO.
- Mode 0, MSB first. The slave answers in frame N with data selected by the command of frame N-1, so callers issue a dummy or next command to read back a result.
- Used as the on-FPGA host for self-test and for bench stimulus of the slave-side command decoders.

Parameters:
- VALUE_WIDTH, 32, frame length in bits.
- CLK_DIV, 4, clk cycles per sclk half-period; must be >= 2 because the slave oversamples sclk in its own clk domain.
- CS_SETUP, 2, clk cycles from cs falling to the first sclk low phase; must be >= 1.
- CS_HOLD, 2, clk cycles from the last sclk falling edge to cs rising; must be >= 1.
- CS_GAP, 4, minimum clk cycles cs stays high between frames; must be >= 1.

Ports:
- clk  in  1  system clock.
- rest  in  1  asynchronous active-low reset.
- start  in  1  request a frame; accepted only when busy=0.
- txValue  in  VALUE_WIDTH  command word; sampled only on the accept cycle.
- busy  out  1  high from the cycle after accept until the end of GAP.
- done  out  1  single-cycle pulse when rxValue updates.
- rxValue  out  VALUE_WIDTH  last received word; held until the next done.
- spi_cs  out  1  chip select, active low.
- spi_sclk  out  1  serial clock, idles low.
- spi_mosi  out  1  master data out.
- spi_miso  in  1  slave data in.

Behaviour:
- All outputs are registered.
- Reset (rest=0, asynchronous):
  - spi_cs=1, spi_sclk=0, spi_mosi=0.
  - busy=0, done=0, rxValue=0.
  - FSM returns to IDLE and all counters clear.
  - A frame in progress is abandoned immediately: cs rises, no done pulse, rxValue is unchanged from 0.
- FSM states: IDLE, SETUP, LOW, HIGH, HOLD, GAP.
- IDLE:
  - On start=1 (accept): latch txValue into the tx shift register, set bitCnt=VALUE_WIDTH-1, drive spi_cs<=0 and spi_mosi<=txValue[MSB], go to SETUP.
  - busy=1 from the next cycle.
- SETUP: hold for CS_SETUP cycles with sclk=0, then go to LOW.
- LOW:
  - sclk=0 for CLK_DIV cycles.
  - On the last cycle: spi_sclk<=1 and sample spi_miso into the LSB of the rx shift register, shifting left. The sample is taken on the same clk edge that raises sclk, i.e. the master samples on the rising edge.
  - Go to HIGH.
- HIGH:
  - sclk=1 for CLK_DIV cycles.
  - On the last cycle: spi_sclk<=0.
  - If bitCnt==0, go to HOLD.
  - Otherwise: bitCnt--, spi_mosi<=next tx bit (MOSI changes on the falling edge), go to LOW.
- HOLD: CS_HOLD cycles with sclk=0 and mosi held. On the last cycle: spi_cs<=1, rxValue<=rx shift register, done<=1 for one cycle, go to GAP.
- GAP:
  - CS_GAP cycles with cs=1, mosi=0, busy=1.
  - Then go to IDLE with busy=0.
  - start may be accepted in the first IDLE cycle.
- Timing totals:
  - cs low time = CS_SETUP + 2*CLK_DIV*VALUE_WIDTH + CS_HOLD cycles (260 at defaults).
  - Accept-to-done latency = that value + 1.
  - Accept-to-next-accept minimum = latency + CS_GAP.
- Boundary conditions:
  - start while busy=1: ignored, no queuing.
  - start held high continuously: back-to-back frames separated by exactly CS_GAP cycles of cs high.
  - txValue changing mid-frame: no effect on the frame in progress.
  - done and a new accept can never coincide.
  - Exactly VALUE_WIDTH rising sclk edges per frame. sclk is never high while cs is high.

Test Plan:
- MISO tied to MOSI, start with txValue=0x4000_0001 → done pulse, rxValue=0x4000_0001; exactly 32 sclk rising edges; cs low for 260 clk cycles.
- Mode-0 slave model returning 0xA5A5_3C01 → rxValue=0xA5A5_3C01; MOSI stable whenever sclk rises; bits sent MSB first.
- Reference slave instantiated, frames 0x1000_0000 then 0x0000_0000 → the second frame's rxValue equals the slave's response to command 1.
- start pulsed again 10 cycles after accept → ignored: one frame only, one done pulse.
- start held high for three frames → cs high exactly 4 cycles between frames; three done pulses.
- rest asserted at bit 15 → cs=1 and sclk=0 within the same cycle, no done pulse, rxValue=0; the next frame after reset release completes correctly.

Source files
------------

// File: rtl/spi_cmd_master_if.sv
// spi_cmd_master_if: request/response handshake between a host and spi_cmd_master
interface spi_cmd_master_if #(parameter int VALUE_WIDTH = 32);
    logic                   start;
    logic [VALUE_WIDTH-1:0] txValue;
    logic                   busy;
    logic                   done;
    logic [VALUE_WIDTH-1:0] rxValue;
    modport master(output start, txValue, input busy, done, rxValue);
    modport slave(input start, txValue, output busy, done, rxValue);
endinterface

// File: rtl/spi_cmd_master.sv
// spi_cmd_master: mode-0 MSB-first SPI master, one full-duplex command/response frame per request
module spi_cmd_master #(
    parameter int VALUE_WIDTH = 32,
    parameter int CLK_DIV     = 4,
    parameter int CS_SETUP    = 2,
    parameter int CS_HOLD     = 2,
    parameter int CS_GAP      = 4
) (
    input  logic            clk,
    input  logic            rest,
    spi_cmd_master_if.slave bus,
    output logic            spi_cs,
    output logic            spi_sclk,
    output logic            spi_mosi,
    input  logic            spi_miso
);
    localparam int BW = $clog2(VALUE_WIDTH);
    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_t;
    state_t                 state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [VALUE_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, rx_value_q, rx_value_d;
    logic                   busy_q, busy_d, done_q, done_d;
    logic                   cs_q, cs_d, sclk_q, sclk_d, mosi_q, mosi_d;
    int                     len;
    logic                   last;
    // the IDLE cycle in which the next start is accepted counts as the final cs-high gap cycle
    always_comb begin
        len = (state_q == LOW || state_q == HIGH) ? CLK_DIV :
              (state_q == SETUP) ? CS_SETUP : (state_q == HOLD) ? CS_HOLD : CS_GAP - 1;
        last = int'(cnt_q) == len - 1;
        state_d = state_q;
        cnt_d = (state_q == IDLE || last) ? '0 : cnt_q + 16'd1;
        bit_cnt_d = bit_cnt_q;
        tx_d = tx_q;
        rx_d = rx_q;
        rx_value_d = rx_value_q;
        busy_d = busy_q;
        done_d = 1'b0;
        cs_d = cs_q;
        sclk_d = sclk_q;
        mosi_d = mosi_q;
        case (state_q)
            IDLE: if (bus.start) begin
                tx_d = bus.txValue;
                bit_cnt_d = BW'(VALUE_WIDTH - 1);
                cs_d = 1'b0;
                mosi_d = bus.txValue[VALUE_WIDTH-1];
                busy_d = 1'b1;
                state_d = SETUP;
            end
            SETUP: if (last) state_d = LOW;
            LOW: if (last) begin
                sclk_d = 1'b1;
                rx_d = {rx_q[VALUE_WIDTH-2:0], spi_miso};
                state_d = HIGH;
            end
            HIGH: if (last) begin
                sclk_d = 1'b0;
                if (bit_cnt_q == '0) state_d = HOLD;
                else begin
                    bit_cnt_d = bit_cnt_q - BW'(1);
                    tx_d = tx_q << 1;
                    mosi_d = tx_q[VALUE_WIDTH-2];
                    state_d = LOW;
                end
            end
            HOLD: if (last) begin
                cs_d = 1'b1;
                mosi_d = 1'b0;
                rx_value_d = rx_q;
                done_d = 1'b1;
                busy_d = CS_GAP > 1;
                state_d = (CS_GAP > 1) ? GAP : IDLE;
            end
            GAP: if (last) begin
                busy_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_q <= IDLE;
            cnt_q <= '0;
            bit_cnt_q <= '0;
            tx_q <= '0;
            rx_q <= '0;
            rx_value_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cs_q <= 1'b1;
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q <= tx_d;
            rx_q <= rx_d;
            rx_value_q <= rx_value_d;
            busy_q <= busy_d;
            done_q <= done_d;
            cs_q <= cs_d;
            sclk_q <= sclk_d;
            mosi_q <= mosi_d;
        end
    end
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.rxValue = rx_value_q;
    assign spi_cs = cs_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;
endmodule

// File: tb/tb_spi_cmd_master.sv
// tb_spi_cmd_master: directed checks of framing, timing, data and reset of spi_cmd_master
module tb_spi_cmd_master;
    logic clk, rest, spi_cs, spi_sclk, spi_mosi, spi_miso;
    spi_cmd_master_if #(.VALUE_WIDTH(32)) bus ();
    spi_cmd_master dut (
        .clk(clk), .rest(rest), .bus(bus), .spi_cs(spi_cs),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    int checks = 0, errors = 0;
    // slave model: loopback, fixed response, or response = previous command ^ 0x5A5A0000
    logic        loop_mode, use_fixed;
    logic [31:0] fixed_resp, s_word, s_cmd, s_resp;
    int          falls = 0, base = 0, sclk_rises = 0;
    logic [4:0]  s_idx;
    initial begin s_resp = 32'h0; s_cmd = 32'h0; s_word = 32'h0; end
    always @(negedge spi_sclk) falls++;
    always @(posedge spi_sclk) begin sclk_rises++; s_cmd = {s_cmd[30:0], spi_mosi}; end
    always @(negedge spi_cs) begin s_word = use_fixed ? fixed_resp : s_resp; base = falls; end
    always @(posedge spi_cs) s_resp = s_cmd ^ 32'h5A5A_0000;
    assign s_idx = 5'(falls - base);
    assign spi_miso = loop_mode ? spi_mosi : s_word[~s_idx];
    int   low_run = 0, high_run = 0, last_low = 0, last_high = 0, done_cnt = 0, sclk_bad = 0, mosi_bad = 0;
    logic prev_sclk = 1'b0, prev_mosi = 1'b0;
    always @(negedge clk) begin
        if (!spi_cs) begin
            if (high_run != 0) last_high = high_run;
            high_run = 0;
            low_run++;
        end else begin
            if (low_run != 0) last_low = low_run;
            low_run = 0;
            high_run++;
        end
        if (bus.done) done_cnt++;
        if (spi_cs && spi_sclk) sclk_bad++;
        if (spi_sclk && !prev_sclk && spi_mosi !== prev_mosi) mosi_bad++;
        prev_sclk = spi_sclk;
        prev_mosi = spi_mosi;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask
    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 1000) begin @(negedge clk); n++; end
    endtask
    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 400) begin @(negedge clk); n++; end
        check("done_seen", {31'b0, bus.done}, 32'h1);
    endtask
    task automatic run_frame(input logic [31:0] v);
        wait_idle();
        bus.start = 1'b1;
        bus.txValue = v;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
    endtask
    int dc, rs, n;
    initial begin
        rest = 1'b0;
        bus.start = 1'b0;
        bus.txValue = 32'h0;
        loop_mode = 1'b1;
        use_fixed = 1'b0;
        fixed_resp = 32'hA5A5_3C01;
        repeat (3) @(negedge clk);
        check("rst_cs", {31'b0, spi_cs}, 32'h1);
        check("rst_sclk", {31'b0, spi_sclk}, 32'h0);
        check("rst_mosi", {31'b0, spi_mosi}, 32'h0);
        check("rst_busy", {31'b0, bus.busy}, 32'h0);
        check("rst_done", {31'b0, bus.done}, 32'h0);
        check("rst_rx", bus.rxValue, 32'h0);
        rest = 1'b1;
        repeat (2) @(negedge clk);
        rs = sclk_rises;
        run_frame(32'h4000_0001);
        check("loop_rx", bus.rxValue, 32'h4000_0001);
        @(negedge clk);
        check("done_width", {31'b0, bus.done}, 32'h0);
        check("gap_busy", {31'b0, bus.busy}, 32'h1);
        check("sclk_edges", 32'(sclk_rises - rs), 32'd32);
        check("cs_low_len", 32'(last_low), 32'd260);
        loop_mode = 1'b0;
        use_fixed = 1'b1;
        run_frame(32'h1234_5678);
        check("fixed_rx", bus.rxValue, 32'hA5A5_3C01);
        check("msb_first_cmd", s_cmd, 32'h1234_5678);
        check("mosi_stable", 32'(mosi_bad), 32'd0);
        use_fixed = 1'b0;
        run_frame(32'h1000_0000);
        run_frame(32'h0000_0000);
        check("ref_resp", bus.rxValue, 32'h4A5A_0000);
        loop_mode = 1'b1;
        wait_idle();
        dc = done_cnt;
        bus.start = 1'b1;
        bus.txValue = 32'h0F0F_F0F0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.start = 1'b1;
        bus.txValue = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.start = 1'b0;
        bus.txValue = 32'h0;
        wait_done();
        check("busy_ignore_rx", bus.rxValue, 32'h0F0F_F0F0);
        repeat (300) @(negedge clk);
        check("busy_ignore_cnt", 32'(done_cnt - dc), 32'd1);
        wait_idle();
        dc = done_cnt;
        bus.start = 1'b1;
        bus.txValue = 32'h8000_0001;
        n = 0;
        while (done_cnt - dc < 3 && n < 1000) begin @(negedge clk); n++; end
        bus.start = 1'b0;
        repeat (300) @(negedge clk);
        check("held_frames", 32'(done_cnt - dc), 32'd3);
        check("held_gap", 32'(last_high), 32'd4);
        check("held_rx", bus.rxValue, 32'h8000_0001);
        wait_idle();
        rs = sclk_rises;
        bus.start = 1'b1;
        bus.txValue = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (sclk_rises - rs < 16 && n < 400) begin @(negedge clk); n++; end
        dc = done_cnt;
        rest = 1'b0;
        #1;
        check("abort_cs", {31'b0, spi_cs}, 32'h1);
        check("abort_sclk", {31'b0, spi_sclk}, 32'h0);
        check("abort_rx", bus.rxValue, 32'h0);
        check("abort_busy", {31'b0, bus.busy}, 32'h0);
        check("abort_done", {31'b0, bus.done}, 32'h0);
        repeat (3) @(negedge clk);
        rest = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - dc), 32'd0);
        run_frame(32'h1357_9BDF);
        check("post_reset_rx", bus.rxValue, 32'h1357_9BDF);
        check("sclk_while_cs_high", 32'(sclk_bad), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
